// File: rtl/npc_mem_pkg.sv
// Shared definitions for the IFU/LSU memory arbiter: FSM encoding, owner
// encoding, the latched-request record and the default timeout.
package npc_mem_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  localparam int TIMEOUT_DEF = 255;

  // Fields captured at accept; IFU entries carry zeroed write fields.
  typedef struct packed {
    logic        owner;
    logic        wen;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } txn_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the arbiter; slave = arbiter view,
// master = the surrounding IFU/LSU/memory view.
interface mem_arbiter_if #(
  parameter int AW = 32
);
  logic          ifu_req_valid;
  logic          ifu_req_ready;
  logic [AW-1:0] ifu_addr;
  logic          ifu_resp_valid;
  logic [31:0]   ifu_rdata;
  logic          ifu_resp_err;

  logic          lsu_req_valid;
  logic          lsu_req_ready;
  logic [AW-1:0] lsu_addr;
  logic          lsu_wen;
  logic [31:0]   lsu_wdata;
  logic [3:0]    lsu_wmask;
  logic          lsu_resp_valid;
  logic [31:0]   lsu_rdata;
  logic          lsu_resp_err;

  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [AW-1:0] mem_addr;
  logic          mem_wen;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wmask;
  logic          mem_resp_valid;
  logic [31:0]   mem_rdata;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata
  );
endinterface

// File: rtl/arb_rr2.sv
// Two-requester round-robin picker; purely combinational, grant is one-hot
// and indexed by owner encoding.
module arb_rr2
  import npc_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic [1:0] gnt,
  output logic       win
);

  always_comb begin
    win = OWN_IFU;
    if (req[OWN_IFU] && req[OWN_LSU]) win = ~last_owner;
    else if (req[OWN_LSU])            win = OWN_LSU;
    gnt = '0;
    if (|req) gnt[win] = 1'b1;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding IFU/LSU memory arbiter: IDLE accepts one request,
// ISSUE presents it to memory, WAIT collects the response or times out.
module mem_arbiter
  import npc_mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int AW      = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  localparam int TW = $clog2(TIMEOUT + 1);
  // Decision is registered, so firing one count early lands the error
  // pulse exactly TIMEOUT cycles after accept.
  localparam logic [TW-1:0] TMO_AT = TW'((TIMEOUT > 1) ? TIMEOUT - 2 : 0);

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          last_q, last_d;
  logic [AW-1:0] addr_q, addr_d;
  txn_t          txn_q, txn_d;

  logic          ifu_rv_q, ifu_rv_d, lsu_rv_q, lsu_rv_d;
  logic          ifu_err_q, ifu_err_d, lsu_err_q, lsu_err_d;
  logic [31:0]   ifu_rdata_q, ifu_rdata_d, lsu_rdata_q, lsu_rdata_d;

  logic [1:0]    gnt;
  logic          win;
  logic          tmo;
  logic          done, done_err;
  logic [31:0]   done_data;

  arb_rr2 u_rr (
    .req        ({bus.lsu_req_valid, bus.ifu_req_valid}),
    .last_owner (last_q),
    .gnt        (gnt),
    .win        (win)
  );

  assign tmo = (timer_q == TMO_AT);

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    last_d      = last_q;
    addr_d      = addr_q;
    txn_d       = txn_q;
    ifu_rv_d    = 1'b0;
    lsu_rv_d    = 1'b0;
    ifu_err_d   = 1'b0;
    lsu_err_d   = 1'b0;
    ifu_rdata_d = ifu_rdata_q;
    lsu_rdata_d = lsu_rdata_q;
    done        = 1'b0;
    done_err    = 1'b0;
    done_data   = 32'h0;

    case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          txn_d.owner = win;
          txn_d.wen   = (win == OWN_LSU) & bus.lsu_wen;
          txn_d.wmask = (win == OWN_LSU) ? bus.lsu_wmask : 4'h0;
          txn_d.wdata = (win == OWN_LSU) ? bus.lsu_wdata : 32'h0;
          addr_d      = (win == OWN_LSU) ? bus.lsu_addr  : bus.ifu_addr;
          last_d      = win;
          timer_d     = '0;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        timer_d = timer_q + TW'(1);
        if (tmo) begin
          done     = 1'b1;
          done_err = 1'b1;
        end else if (bus.mem_req_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        timer_d = timer_q + TW'(1);
        // A response on the deadline cycle still counts as a good one.
        if (bus.mem_resp_valid) begin
          done      = 1'b1;
          done_data = bus.mem_rdata;
        end else if (tmo) begin
          done     = 1'b1;
          done_err = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (done) begin
      state_d = ST_IDLE;
      if (txn_q.owner == OWN_LSU) begin
        lsu_rv_d    = 1'b1;
        lsu_err_d   = done_err;
        lsu_rdata_d = done_data;
      end else begin
        ifu_rv_d    = 1'b1;
        ifu_err_d   = done_err;
        ifu_rdata_d = done_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      last_q      <= OWN_IFU;
      addr_q      <= '0;
      txn_q       <= '0;
      ifu_rv_q    <= 1'b0;
      lsu_rv_q    <= 1'b0;
      ifu_err_q   <= 1'b0;
      lsu_err_q   <= 1'b0;
      ifu_rdata_q <= 32'h0;
      lsu_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      txn_q       <= txn_d;
      ifu_rv_q    <= ifu_rv_d;
      lsu_rv_q    <= lsu_rv_d;
      ifu_err_q   <= ifu_err_d;
      lsu_err_q   <= lsu_err_d;
      ifu_rdata_q <= ifu_rdata_d;
      lsu_rdata_q <= lsu_rdata_d;
    end
  end

  assign bus.ifu_req_ready  = (state_q == ST_IDLE) & gnt[OWN_IFU];
  assign bus.lsu_req_ready  = (state_q == ST_IDLE) & gnt[OWN_LSU];
  assign bus.ifu_resp_valid = ifu_rv_q;
  assign bus.ifu_resp_err   = ifu_err_q;
  assign bus.ifu_rdata      = ifu_rdata_q;
  assign bus.lsu_resp_valid = lsu_rv_q;
  assign bus.lsu_resp_err   = lsu_err_q;
  assign bus.lsu_rdata      = lsu_rdata_q;

  assign bus.mem_req_valid  = (state_q == ST_ISSUE);
  assign bus.mem_addr       = addr_q;
  assign bus.mem_wen        = txn_q.wen;
  assign bus.mem_wmask      = txn_q.wmask;
  assign bus.mem_wdata      = txn_q.wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed + randomized checks of mem_arbiter against a timeline model:
// response lands 3+ready_delay+resp_delay cycles after accept, or errors at TIMEOUT.
module tb_mem_arbiter;

  localparam int TMO = 8;
  localparam int AW  = 32;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  bit          last_lsu;
  logic [31:0] exp_ifu_rd, exp_lsu_rd;
  bit          r_iv, r_lv, r_lw;
  int          r_d1, r_d2;

  mem_arbiter_if #(.AW(AW)) bus ();

  mem_arbiter #(.TIMEOUT(TMO), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.ifu_req_valid  = 1'b0;
    bus.ifu_addr       = '0;
    bus.lsu_req_valid  = 1'b0;
    bus.lsu_addr       = '0;
    bus.lsu_wen        = 1'b0;
    bus.lsu_wdata      = '0;
    bus.lsu_wmask      = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {bus.ifu_req_ready, bus.lsu_req_ready, bus.ifu_resp_valid,
                        bus.lsu_resp_valid, bus.ifu_resp_err, bus.lsu_resp_err,
                        bus.mem_req_valid, bus.mem_wen}, 8'h0);
    chk({tag, "_rdata"}, {bus.ifu_rdata, bus.lsu_rdata}, 64'h0);
    chk({tag, "_mem"}, {bus.mem_addr, bus.mem_wdata}, 64'h0);
    chk({tag, "_wmask"}, bus.mem_wmask, 4'h0);
  endtask

  // Asserted mid-cycle so the zeroing must be asynchronous.
  task automatic rst_pulse(input string tag);
    rst_n = 1'b0;
    #1;
    chk_zero(tag);
    last_lsu   = 1'b0;
    exp_ifu_rd = '0;
    exp_lsu_rd = '0;
    tick();
    rst_n = 1'b1;
  endtask

  // Starts and ends at posedge+1 with idle inputs. d1 = cycles mem_req_ready
  // stays low, d2 = cycles from handshake to mem_resp_valid.
  task automatic run_txn(input string tag, input bit iv, input bit lv,
                         input logic [31:0] ia, input logic [31:0] la, input bit lw,
                         input logic [31:0] lwd, input logic [3:0] lwm,
                         input logic [31:0] rd, input int d1, input int d2);
    bit          win, ok, e_wen;
    int          pcyc, mv_last, seen_i, seen_l, cyc_i, cyc_l;
    logic [31:0] e_addr, e_wd, got_i, got_l;
    logic [3:0]  e_wm;
    bit          err_i, err_l;

    win     = (iv && lv) ? !last_lsu : lv;
    ok      = (2 + d1 + d2) <= (TMO - 1);
    pcyc    = ok ? (3 + d1 + d2) : TMO;
    mv_last = ((1 + d1) < (TMO - 1)) ? (1 + d1) : (TMO - 1);
    e_addr  = win ? la : ia;
    e_wen   = win && lw;
    e_wd    = win ? lwd : 32'h0;
    e_wm    = win ? lwm : 4'h0;
    seen_i = 0; seen_l = 0; cyc_i = -1; cyc_l = -1;
    got_i = '0; got_l = '0; err_i = 1'b0; err_l = 1'b0;

    bus.ifu_req_valid = iv;  bus.ifu_addr  = ia;
    bus.lsu_req_valid = lv;  bus.lsu_addr  = la;
    bus.lsu_wen       = lw;  bus.lsu_wdata = lwd;  bus.lsu_wmask = lwm;
    smp();
    chk({tag, "_rdy_ifu"}, bus.ifu_req_ready, iv && !win);
    chk({tag, "_rdy_lsu"}, bus.lsu_req_ready, win);
    last_lsu = win;

    for (int k = 1; k <= TMO + 2; k++) begin
      tick();
      bus.ifu_req_valid = (k < pcyc) ? ($urandom_range(0, 1) != 0) : 1'b0;
      bus.lsu_req_valid = (k < pcyc) ? ($urandom_range(0, 1) != 0) : 1'b0;
      bus.mem_req_ready = (k == 1 + d1);
      if (k == 2 + d1 + d2) begin
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = rd;
      end else begin
        bus.mem_resp_valid = (k <= 1 + d1) ? ($urandom_range(0, 1) != 0) : 1'b0;
        bus.mem_rdata      = $urandom;
      end
      smp();
      chk($sformatf("%s_mv%0d", tag, k), bus.mem_req_valid, k <= mv_last);
      if (k <= mv_last) begin
        chk($sformatf("%s_addr%0d", tag, k), bus.mem_addr, e_addr);
        chk($sformatf("%s_fld%0d", tag, k), {bus.mem_wen, bus.mem_wmask, bus.mem_wdata},
            {e_wen, e_wm, e_wd});
      end
      if (k < pcyc)
        chk($sformatf("%s_busy_rdy%0d", tag, k), {bus.ifu_req_ready, bus.lsu_req_ready}, 2'b00);
      if (bus.ifu_resp_valid) begin
        seen_i++; cyc_i = k; got_i = bus.ifu_rdata; err_i = bus.ifu_resp_err;
      end
      if (bus.lsu_resp_valid) begin
        seen_l++; cyc_l = k; got_l = bus.lsu_rdata; err_l = bus.lsu_resp_err;
      end
    end

    if (win) begin
      exp_lsu_rd = ok ? rd : 32'h0;
      chk({tag, "_npulse"}, seen_l, 1);
      chk({tag, "_pcyc"}, cyc_l, pcyc);
      chk({tag, "_data"}, got_l, exp_lsu_rd);
      chk({tag, "_err"}, err_l, !ok);
      chk({tag, "_other"}, seen_i, 0);
    end else begin
      exp_ifu_rd = ok ? rd : 32'h0;
      chk({tag, "_npulse"}, seen_i, 1);
      chk({tag, "_pcyc"}, cyc_i, pcyc);
      chk({tag, "_data"}, got_i, exp_ifu_rd);
      chk({tag, "_err"}, err_i, !ok);
      chk({tag, "_other"}, seen_l, 0);
    end
    chk({tag, "_hold"}, {bus.ifu_rdata, bus.lsu_rdata}, {exp_ifu_rd, exp_lsu_rd});
    tick();
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    last_lsu   = 1'b0;
    exp_ifu_rd = '0;
    exp_lsu_rd = '0;
    #1;
    chk_zero("por");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Minimum-latency fetch.
    run_txn("fetch", 1, 0, 32'h8000_0000, 0, 0, 0, 0, 32'h0010_0073, 0, 0);

    // Ties straight out of reset: LSU, IFU, LSU.
    rst_pulse("rst_tie");
    tick();
    run_txn("tie1", 1, 1, 32'h8000_0010, 32'h8000_0800, 0, 0, 0, 32'h1111_0001, 0, 1);
    run_txn("tie2", 1, 1, 32'h8000_0014, 32'h8000_0804, 1, 32'h5555_AAAA, 4'h5, 32'h1111_0002, 1, 0);
    run_txn("tie3", 1, 1, 32'h8000_0018, 32'h8000_0808, 0, 0, 0, 32'h1111_0003, 0, 0);

    // Stalled store, fields must hold.
    run_txn("store", 0, 1, 0, 32'h8000_1000, 1, 32'hDEAD_BEEF, 4'hF, 32'h0, 4, 0);

    // Memory never answers.
    run_txn("tmo", 0, 1, 0, 32'h8000_2000, 0, 0, 0, 32'h1234_5678, 0, 99);

    // Deadline boundaries.
    run_txn("edge_ok",   0, 1, 0, 32'h8000_2100, 0, 0, 0, 32'hA5A5_0001, 0, 5);
    run_txn("edge_late", 0, 1, 0, 32'h8000_2104, 0, 0, 0, 32'hA5A5_0002, 0, 6);
    run_txn("edge_wait", 1, 0, 32'h8000_2108, 0, 0, 0, 0, 32'hA5A5_0003, 5, 0);
    run_txn("edge_iss",  1, 0, 32'h8000_210C, 0, 0, 0, 0, 32'hA5A5_0004, 6, 0);

    // Reset while waiting, then a stray response.
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h8000_3000;
    smp();
    chk("rw_acc", bus.lsu_req_ready, 1'b1);
    tick();
    bus.lsu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    rst_pulse("rst_wait");
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'hBAD0_BAD0;
    for (int k = 0; k < 4; k++) begin
      smp();
      chk($sformatf("rw_quiet%0d", k), {bus.ifu_resp_valid, bus.lsu_resp_valid, bus.mem_req_valid}, 3'b000);
      tick();
      bus.mem_resp_valid = 1'b0;
    end
    run_txn("post_rst", 1, 0, 32'h8000_3100, 0, 0, 0, 0, 32'h0000_0013, 1, 1);

    // Back-to-back: LSU accepted in the IFU response cycle.
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_0040;
    smp();
    chk("b2b_acc0", bus.ifu_req_ready, 1'b1);
    last_lsu = 1'b0;
    tick();
    bus.ifu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'h0000_0513;
    tick();
    bus.mem_resp_valid = 1'b0;
    bus.lsu_req_valid  = 1'b1;
    bus.lsu_addr       = 32'h8000_4000;
    bus.lsu_wen        = 1'b1;
    bus.lsu_wdata      = 32'hCAFE_F00D;
    bus.lsu_wmask      = 4'h3;
    smp();
    exp_ifu_rd = 32'h0000_0513;
    chk("b2b_ifu_pulse", {bus.ifu_resp_valid, bus.ifu_resp_err}, 2'b10);
    chk("b2b_ifu_data", bus.ifu_rdata, exp_ifu_rd);
    chk("b2b_acc1", bus.lsu_req_ready, 1'b1);
    last_lsu = 1'b1;
    tick();
    bus.lsu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    smp();
    chk("b2b_mv", bus.mem_req_valid, 1'b1);
    chk("b2b_addr", bus.mem_addr, 32'h8000_4000);
    chk("b2b_fld", {bus.mem_wen, bus.mem_wmask, bus.mem_wdata}, {1'b1, 4'h3, 32'hCAFE_F00D});
    tick();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'h1122_3344;
    tick();
    bus.mem_resp_valid = 1'b0;
    smp();
    exp_lsu_rd = 32'h1122_3344;
    chk("b2b_lsu_pulse", {bus.lsu_resp_valid, bus.lsu_resp_err, bus.ifu_resp_valid}, 3'b100);
    chk("b2b_lsu_data", bus.lsu_rdata, exp_lsu_rd);
    tick();
    idle_inputs();

    // Randomized traffic against the timeline model.
    for (int n = 0; n < 40; n++) begin
      r_iv = ($urandom_range(0, 1) != 0);
      r_lv = ($urandom_range(0, 1) != 0);
      if (!r_iv && !r_lv) r_lv = 1'b1;
      r_lw = ($urandom_range(0, 1) != 0);
      r_d1 = $urandom_range(0, 7);
      r_d2 = $urandom_range(0, 7);
      run_txn($sformatf("rnd%0d", n), r_iv, r_lv, $urandom, $urandom, r_lw,
              $urandom, 4'($urandom_range(0, 15)), $urandom, r_d1, r_d2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, meaning: cycles in ISSUE+WAIT before an error response is returned.
REQ-002 Parameter AW, default 32, meaning: address width; data width is fixed at 32.
REQ-003 clk  in  1  the single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 ifu_req_valid  in  1  IFU fetch request.
REQ-006 ifu_req_ready  out  1  IFU request accepted this cycle when high with valid.
REQ-007 ifu_addr  in  AW  fetch address.
REQ-008 ifu_resp_valid  out  1  one-cycle response pulse to IFU.
REQ-009 ifu_rdata  out  32  fetched instruction.
REQ-010 ifu_resp_err  out  1  response is a timeout error.
REQ-011 lsu_req_valid / lsu_req_ready  in / out  1 / 1  LSU request handshake.
REQ-012 lsu_addr, lsu_wen, lsu_wdata, lsu_wmask  in  AW, 1, 32, 4  LSU access fields.
REQ-013 lsu_resp_valid, lsu_rdata, lsu_resp_err  out  1, 32, 1  LSU response.
REQ-014 mem_req_valid / mem_req_ready  out / in  1 / 1  memory-side request handshake.
REQ-015 mem_addr, mem_wen, mem_wdata, mem_wmask  out  AW, 1, 32, 4  memory access fields.
REQ-016 mem_resp_valid, mem_rdata  in  1, 32  memory response; arrives only after mem_req_valid & mem_req_ready.

Function
REQ-017 Three states: IDLE, ISSUE, WAIT; exactly one transaction outstanding.
REQ-018 IDLE: ifu_req_ready/lsu_req_ready are driven combinationally and only to the arbitration winner; in ISSUE/WAIT both are 0.
REQ-019 Arbitration: single valid requester wins; both valid -> the owner not granted last wins (round-robin); last_owner resets to IFU, so LSU wins the first tie.
REQ-020 On accept (valid & ready): latch owner, addr, wen, wdata, wmask; update last_owner; next state ISSUE.
REQ-021 IFU transactions force mem_wen=0, mem_wmask=4'h0, mem_wdata=0.
REQ-022 ISSUE: mem_req_valid=1 with latched fields held stable until mem_req_ready; on mem_req_ready -> WAIT.
REQ-023 WAIT: on mem_resp_valid, register mem_rdata into owner's rdata, pulse owner's resp_valid for exactly one cycle next cycle with err=0; next state IDLE.
REQ-024 Timer counts every cycle in ISSUE and WAIT, cleared on accept; reaching TIMEOUT -> owner resp_valid pulse with err=1, rdata=0, mem_req_valid dropped, next state IDLE.
REQ-025 mem_resp_valid in the same cycle as the timeout -> normal response wins, err=0.
REQ-026 mem_resp_valid in IDLE or ISSUE is ignored.
REQ-027 Non-owner resp_valid is 0 always; rdata outputs hold last value between pulses.
REQ-028 Minimum latency: accept cycle 0, mem_req_valid cycle 1, mem_resp_valid cycle 2, resp_valid cycle 3.
REQ-029 The response-pulse cycle is an IDLE cycle; a new request may be accepted in it (back-to-back).
REQ-030 Requesters have no response back-pressure; responses are always consumed.

Reset
REQ-031 rst_n low: state IDLE, all valid/ready/err outputs 0, rdata 0, mem fields 0, timer 0, last_owner IFU, immediately and asynchronously.
REQ-032 Reset mid-transaction drops it; no response is issued after rst_n deasserts.

Structure
REQ-033 Shared package npc_mem_pkg holds the state enum, owner encoding (OWN_IFU=0, OWN_LSU=1) and TIMEOUT default.
REQ-034 One sub-module arb_rr2: two-request round-robin picker, combinational grant from requests and last_owner.

Verification
REQ-035 IFU only, addr 0x80000000, mem ready immediately, rdata 0x00100073 one cycle later -> ifu_resp_valid at cycle 3, ifu_rdata 0x00100073, err 0.
REQ-036 IFU and LSU valid together from reset, twice -> LSU granted first, IFU second; grants alternate.
REQ-037 LSU store addr 0x80001000, wdata 0xDEADBEEF, wmask 4'b1111, mem_req_ready low 4 cycles -> mem fields stable throughout, single lsu_resp_valid.
REQ-038 TIMEOUT=8, memory never responds -> lsu_resp_valid with err=1, rdata 0, 8 cycles after accept; then state IDLE.
REQ-039 rst_n pulsed low in WAIT, later stray mem_resp_valid -> no resp_valid, next request accepted normally.
REQ-040 mem_resp_valid exactly on the TIMEOUT cycle -> err 0, data delivered.
